// File: rtl/health_tracker_if.sv
// Signal bundle between the stage/collision logic (master) and health_tracker (slave).
interface health_tracker_if #(
  parameter int HP_W = 7
) ();
  logic            start_l;
  logic            battle_l;
  logic            Player_Hit;
  logic [HP_W-1:0] Player_Dmg;
  logic            NPC_Hit;
  logic [HP_W-1:0] NPC_Dmg;
  logic [HP_W-1:0] Player_HP;
  logic [HP_W-1:0] NPC_HP;
  logic            Player_Dead;
  logic            NPC_Dead;

  modport master (
    output start_l, battle_l, Player_Hit, Player_Dmg, NPC_Hit, NPC_Dmg,
    input  Player_HP, NPC_HP, Player_Dead, NPC_Dead
  );

  modport slave (
    input  start_l, battle_l, Player_Hit, Player_Dmg, NPC_Hit, NPC_Dmg,
    output Player_HP, NPC_HP, Player_Dead, NPC_Dead
  );
endinterface

// File: rtl/health_tracker.sv
// Per-combatant HP tracker: applies hits with invulnerability windows during battle and
// holds a death flag for DEAD_HOLD frames so the stage controller can leave WIN/LOSE.
module health_tracker #(
  parameter int MAX_HP        = 100,
  parameter int HP_W          = 7,
  parameter int INVULN_FRAMES = 30,
  parameter int DEAD_HOLD     = 60
) (
  input  logic            Clk,
  input  logic            Reset,
  health_tracker_if.slave hif
);

  localparam int INV_W  = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;
  localparam int HOLD_W = $clog2(DEAD_HOLD + 1);

  localparam logic [HP_W-1:0]   HP_FULL   = HP_W'(MAX_HP);
  localparam logic [HP_W-1:0]   HP_ZERO   = {HP_W{1'b0}};
  localparam logic [INV_W-1:0]  INV_LOAD  = INV_W'(INVULN_FRAMES);
  localparam logic [INV_W-1:0]  INV_ZERO  = {INV_W{1'b0}};
  localparam logic [INV_W-1:0]  INV_ONE   = INV_W'(1'b1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(DEAD_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp,
                                               input logic [HP_W-1:0] dmg);
    if (dmg >= hp) return {HP_W{1'b0}};
    else           return hp - dmg;
  endfunction

  state_t            state_r, state_nxt_s;
  logic [HP_W-1:0]   player_hp_r, player_hp_nxt_s;
  logic [HP_W-1:0]   npc_hp_r, npc_hp_nxt_s;
  logic              player_dead_r, player_dead_nxt_s;
  logic              npc_dead_r, npc_dead_nxt_s;
  logic [INV_W-1:0]  player_inv_r, player_inv_nxt_s;
  logic [INV_W-1:0]  npc_inv_r, npc_inv_nxt_s;
  logic [HOLD_W-1:0] hold_r, hold_nxt_s;
  logic              player_apply_s, npc_apply_s;

  assign player_apply_s = hif.Player_Hit && (hif.Player_Dmg != HP_ZERO) && (player_inv_r == INV_ZERO);
  assign npc_apply_s    = hif.NPC_Hit && (hif.NPC_Dmg != HP_ZERO) && (npc_inv_r == INV_ZERO);

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_r       <= ST_IDLE;
      player_hp_r   <= HP_FULL;
      npc_hp_r      <= HP_FULL;
      player_dead_r <= 1'b0;
      npc_dead_r    <= 1'b0;
      player_inv_r  <= INV_ZERO;
      npc_inv_r     <= INV_ZERO;
      hold_r        <= HOLD_ZERO;
    end else begin
      state_r       <= state_nxt_s;
      player_hp_r   <= player_hp_nxt_s;
      npc_hp_r      <= npc_hp_nxt_s;
      player_dead_r <= player_dead_nxt_s;
      npc_dead_r    <= npc_dead_nxt_s;
      player_inv_r  <= player_inv_nxt_s;
      npc_inv_r     <= npc_inv_nxt_s;
      hold_r        <= hold_nxt_s;
    end
  end

  // Next-state selection; a death in ACTIVE outranks a battle_l drop.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (hif.battle_l) state_nxt_s = ST_ACTIVE;
        else              state_nxt_s = ST_IDLE;
      end
      ST_ACTIVE: begin
        if ((npc_hp_nxt_s == HP_ZERO) || (player_hp_nxt_s == HP_ZERO)) state_nxt_s = ST_HOLD;
        else if (!hif.battle_l)                                         state_nxt_s = ST_IDLE;
        else                                                            state_nxt_s = ST_ACTIVE;
      end
      ST_HOLD: begin
        if (hif.start_l)           state_nxt_s = ST_IDLE;
        else if (hold_r <= HOLD_ONE) state_nxt_s = ST_DONE;
        else                       state_nxt_s = ST_HOLD;
      end
      ST_DONE: begin
        if (hif.start_l) state_nxt_s = ST_IDLE;
        else             state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of HP, invulnerability, hold counter and death flags.
  always_comb begin
    player_hp_nxt_s   = player_hp_r;
    npc_hp_nxt_s      = npc_hp_r;
    player_dead_nxt_s = player_dead_r;
    npc_dead_nxt_s    = npc_dead_r;
    player_inv_nxt_s  = player_inv_r;
    npc_inv_nxt_s     = npc_inv_r;
    hold_nxt_s        = hold_r;
    case (state_r)
      ST_IDLE: begin
        player_dead_nxt_s = 1'b0;
        npc_dead_nxt_s    = 1'b0;
        if (hif.start_l) begin
          player_hp_nxt_s  = HP_FULL;
          npc_hp_nxt_s     = HP_FULL;
          player_inv_nxt_s = INV_ZERO;
          npc_inv_nxt_s    = INV_ZERO;
        end else begin
          player_hp_nxt_s  = player_hp_r;
        end
      end
      ST_ACTIVE: begin
        player_dead_nxt_s = 1'b0;
        npc_dead_nxt_s    = 1'b0;
        if (player_apply_s) begin
          player_hp_nxt_s  = sat_sub(player_hp_r, hif.Player_Dmg);
          player_inv_nxt_s = INV_LOAD;
        end else if (player_inv_r != INV_ZERO) begin
          player_inv_nxt_s = player_inv_r - INV_ONE;
        end else begin
          player_inv_nxt_s = INV_ZERO;
        end
        if (npc_apply_s) begin
          npc_hp_nxt_s  = sat_sub(npc_hp_r, hif.NPC_Dmg);
          npc_inv_nxt_s = INV_LOAD;
        end else if (npc_inv_r != INV_ZERO) begin
          npc_inv_nxt_s = npc_inv_r - INV_ONE;
        end else begin
          npc_inv_nxt_s = INV_ZERO;
        end
        // NPC death wins a simultaneous double knockout.
        if (npc_hp_nxt_s == HP_ZERO) begin
          npc_dead_nxt_s = 1'b1;
          hold_nxt_s     = HOLD_LOAD;
        end else if (player_hp_nxt_s == HP_ZERO) begin
          player_dead_nxt_s = 1'b1;
          hold_nxt_s        = HOLD_LOAD;
        end else begin
          hold_nxt_s = HOLD_ZERO;
        end
      end
      ST_HOLD: begin
        if (hif.start_l) begin
          player_dead_nxt_s = 1'b0;
          npc_dead_nxt_s    = 1'b0;
          player_hp_nxt_s   = HP_FULL;
          npc_hp_nxt_s      = HP_FULL;
          player_inv_nxt_s  = INV_ZERO;
          npc_inv_nxt_s     = INV_ZERO;
          hold_nxt_s        = HOLD_ZERO;
        end else if (hold_r <= HOLD_ONE) begin
          player_dead_nxt_s = 1'b0;
          npc_dead_nxt_s    = 1'b0;
          hold_nxt_s        = HOLD_ZERO;
        end else begin
          hold_nxt_s = hold_r - HOLD_ONE;
        end
      end
      ST_DONE: begin
        player_dead_nxt_s = 1'b0;
        npc_dead_nxt_s    = 1'b0;
        if (hif.start_l) begin
          player_hp_nxt_s  = HP_FULL;
          npc_hp_nxt_s     = HP_FULL;
          player_inv_nxt_s = INV_ZERO;
          npc_inv_nxt_s    = INV_ZERO;
        end else begin
          player_hp_nxt_s  = player_hp_r;
        end
      end
      default: begin
        player_hp_nxt_s   = HP_FULL;
        npc_hp_nxt_s      = HP_FULL;
        player_dead_nxt_s = 1'b0;
        npc_dead_nxt_s    = 1'b0;
        player_inv_nxt_s  = INV_ZERO;
        npc_inv_nxt_s     = INV_ZERO;
        hold_nxt_s        = HOLD_ZERO;
      end
    endcase
  end

  assign hif.Player_HP   = player_hp_r;
  assign hif.NPC_HP      = npc_hp_r;
  assign hif.Player_Dead = player_dead_r;
  assign hif.NPC_Dead    = npc_dead_r;

endmodule

// File: tb/tb_health_tracker.sv
// Bench for health_tracker: directed scenarios then randomized rounds, each step checked
// against an edge-counting reference model of HP, invulnerability and death-hold rules.
module tb_health_tracker;
  localparam int MAX_HP = 100;
  localparam int HP_W   = 7;
  localparam int F      = 30;
  localparam int D      = 60;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  health_tracker_if #(.HP_W(HP_W)) hif ();

  health_tracker #(
    .MAX_HP(MAX_HP), .HP_W(HP_W), .INVULN_FRAMES(F), .DEAD_HOLD(D)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .hif(hif)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: phase 0 lobby, 1 fighting, 2 death shown, 3 round over.
  int m_phase;
  int m_php, m_nhp;
  bit m_pdead, m_ndead;
  int m_plast, m_nlast;   // edge of last applied hit
  int m_death_edge;
  int edge_no = 0;

  int hi_cnt;
  int len;
  int stop_at;

  task automatic chk_hp(input string tag, input logic [HP_W-1:0] obs, input logic [HP_W-1:0] exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, edge_no);
    end
  endtask

  task automatic chk_flag(input string tag, input logic obs, input logic exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b (edge %0d)", tag, obs, exp, edge_no);
    end
  endtask

  task automatic model_reload();
    m_php   = MAX_HP;
    m_nhp   = MAX_HP;
    m_plast = -1000;
    m_nlast = -1000;
  endtask

  task automatic model_edge(input bit rst, input bit st, input bit bt,
                            input bit ph, input int pd, input bit nh, input int nd);
    if (!rst) begin
      m_phase = 0; model_reload(); m_pdead = 1'b0; m_ndead = 1'b0;
    end else if (m_phase == 0) begin
      if (st) model_reload();
      if (bt) m_phase = 1;
    end else if (m_phase == 1) begin
      if (ph && pd != 0 && edge_no > m_plast + F) begin
        m_php = (pd >= m_php) ? 0 : m_php - pd;
        m_plast = edge_no;
      end
      if (nh && nd != 0 && edge_no > m_nlast + F) begin
        m_nhp = (nd >= m_nhp) ? 0 : m_nhp - nd;
        m_nlast = edge_no;
      end
      if (m_nhp == 0) begin
        m_ndead = 1'b1; m_phase = 2; m_death_edge = edge_no;
      end else if (m_php == 0) begin
        m_pdead = 1'b1; m_phase = 2; m_death_edge = edge_no;
      end else if (!bt) begin
        m_phase = 0;
      end
    end else if (m_phase == 2) begin
      if (st) begin
        m_pdead = 1'b0; m_ndead = 1'b0; model_reload(); m_phase = 0;
      end else if (edge_no == m_death_edge + D) begin
        m_pdead = 1'b0; m_ndead = 1'b0; m_phase = 3;
      end
    end else begin
      if (st) begin
        model_reload(); m_phase = 0;
      end
    end
  endtask

  task automatic step(input bit rst, input bit st, input bit bt,
                      input bit ph, input int pd, input bit nh, input int nd);
    logic [HP_W-1:0] exp_p, exp_n;
    Reset          = rst;
    hif.start_l    = st;
    hif.battle_l   = bt;
    hif.Player_Hit = ph;
    hif.Player_Dmg = pd[HP_W-1:0];
    hif.NPC_Hit    = nh;
    hif.NPC_Dmg    = nd[HP_W-1:0];
    @(posedge Clk);
    edge_no++;
    model_edge(rst, st, bt, ph, pd, nh, nd);
    #1;
    vectors++;
    exp_p = m_php[HP_W-1:0];
    exp_n = m_nhp[HP_W-1:0];
    chk_hp("player_hp", hif.Player_HP, exp_p);
    chk_hp("npc_hp", hif.NPC_HP, exp_n);
    chk_flag("player_dead", hif.Player_Dead, m_pdead);
    chk_flag("npc_dead", hif.NPC_Dead, m_ndead);
  endtask

  task automatic rstep(input bit rst, input bit st, input bit bt);
    bit ph, nh;
    int pd, nd;
    ph = ($urandom_range(0, 3) == 0);
    nh = ($urandom_range(0, 3) == 0);
    pd = ($urandom_range(0, 9) == 0) ? 127 : int'($urandom_range(0, 25));
    nd = ($urandom_range(0, 9) == 0) ? 127 : int'($urandom_range(0, 25));
    step(rst, st, bt, ph, pd, nh, nd);
  endtask

  initial begin
    // Reset, then lobby with start_l
    step(1'b0, 1'b0, 1'b0, 1'b1, 20, 1'b1, 20);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    chk_hp("reset_player_hp", hif.Player_HP, 7'd100);
    chk_flag("reset_npc_dead", hif.NPC_Dead, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0);

    // Entry edge ignores the hit, then two 40-damage hits 31 frames apart
    step(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1, 40);
    chk_hp("entry_hit_ignored", hif.NPC_HP, 7'd100);
    step(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1, 40);
    chk_hp("npc_hp_60", hif.NPC_HP, 7'd60);
    for (int i = 0; i < F; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1, 40);
    chk_hp("invuln_held_60", hif.NPC_HP, 7'd60);
    step(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1, 40);
    chk_hp("npc_hp_20", hif.NPC_HP, 7'd20);
    chk_flag("npc_alive", hif.NPC_Dead, 1'b0);

    // Restart, consecutive 10-damage hits
    step(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1, 10);
    step(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1, 10);
    chk_hp("npc_hp_90", hif.NPC_HP, 7'd90);
    for (int i = 0; i < F - 1; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1, 10);
    chk_hp("npc_hp_80", hif.NPC_HP, 7'd80);

    // Player to 5, then a 50-damage hit kills; flag held exactly D frames
    step(1'b1, 1'b0, 1'b1, 1'b1, 95, 1'b0, 0);
    chk_hp("player_hp_5", hif.Player_HP, 7'd5);
    for (int i = 0; i < F; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 50, 1'b0, 0);
    chk_hp("player_hp_0", hif.Player_HP, 7'd0);
    chk_flag("player_dead_set", hif.Player_Dead, 1'b1);
    hi_cnt = 1;
    for (int i = 0; i < D + 4; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1, 3, 1'b1, 3);
      if (hif.Player_Dead === 1'b1) hi_cnt++;
    end
    chk_hp("dead_hold_frames", hi_cnt[HP_W-1:0], 7'd60);
    chk_hp("done_frozen_npc", hif.NPC_HP, 7'd80);
    step(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
    chk_hp("reload_player", hif.Player_HP, 7'd100);
    chk_hp("reload_npc", hif.NPC_HP, 7'd100);

    // Simultaneous fatal hits: NPC_Dead only; start_l at hold frame 20
    step(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 90, 1'b1, 90);
    for (int i = 0; i < F; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 10, 1'b1, 10);
    chk_hp("tie_player_hp", hif.Player_HP, 7'd0);
    chk_flag("tie_npc_dead", hif.NPC_Dead, 1'b1);
    chk_flag("tie_player_dead", hif.Player_Dead, 1'b0);
    for (int i = 0; i < 19; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
    chk_flag("hold_restart_flag", hif.NPC_Dead, 1'b0);
    chk_hp("hold_restart_hp", hif.NPC_HP, 7'd100);

    // Reset mid-hold, then hits with battle_l low
    step(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1, 100);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    chk_hp("reset_hold_npc", hif.NPC_HP, 7'd100);
    chk_flag("reset_hold_flag", hif.NPC_Dead, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 30, 1'b1, 30);
    chk_hp("idle_hit_ignored", hif.Player_HP, 7'd100);

    // Randomized rounds
    for (int r = 0; r < 25; r++) begin
      rstep(1'b1, 1'b1, 1'b0);
      rstep(1'b1, 1'b1, 1'b0);
      len = int'($urandom_range(20, 150));
      for (int k = 0; k < len && m_phase != 2; k++) begin
        if ((r % 8) == 5 && k == 40) rstep(1'b0, 1'b0, 1'b1);
        else                         rstep(1'b1, 1'b0, 1'b1);
      end
      if (m_phase == 1) rstep(1'b1, 1'b1, 1'b0);
      if (m_phase == 2) begin
        stop_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, D + 2)) : 1000;
        for (int k = 0; k < D + 5; k++) rstep(1'b1, (k == stop_at), 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
